panda_instr_fetch: RTL

Instruction fetch unit for the Panda core. It is the producer side of the 32-bit instruction word that the decode stage consumes.
- Generates sequential PCs from a boot address.
- Issues requests on a req/gnt/rvalid instruction-memory bus.
- Buffers returned words with their PCs in a small prefetch FIFO.
- Presents them to decode with a valid/ready handshake.
- Flushes and restarts on branch/jump redirects from execute.

---
 rtl/panda_instr_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/panda_instr_fetch.sv
// Panda core instruction fetch: PC generation, req/gnt/rvalid bus master,
// prefetch FIFO toward decode, and redirect flush with response discard.
module panda_instr_fetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_mem_instr [FIFO_DEPTH];
  logic [31:0]   r_mem_pc    [FIFO_DEPTH];

  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   w_resp_pc_nxt;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] w_discard_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_target;
  logic [CW:0]   w_inflight;
  logic          w_unused_pc_lsb;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  assign w_target        = {redirect_pc_i[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  // Outstanding requests plus buffered words never exceed the FIFO size,
  // so every response always has a slot waiting for it.
  assign w_inflight  = {1'b0, r_outstanding} + {1'b0, r_count};
  assign instr_req_o = !rst_i && (w_inflight < DEPTH_W);
  assign instr_addr_o = r_fetch_pc;

  assign w_grant = instr_req_o && instr_gnt_i;
  assign w_push  = instr_rvalid_i && !redirect_i && (r_discard == '0);
  assign w_pop   = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_mem_instr[r_rptr];
  assign instr_pc_o    = r_mem_pc[r_rptr];

  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_resp_pc_nxt     = r_resp_pc;
    w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(instr_rvalid_i);
    w_discard_nxt     = r_discard;
    w_count_nxt       = r_count + CW'(w_push) - CW'(w_pop);
    w_wptr_nxt        = r_wptr;
    w_rptr_nxt        = r_rptr;
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      w_fetch_pc_nxt = w_target;
      w_resp_pc_nxt  = w_target;
      w_discard_nxt  = w_outstanding_nxt;
      w_count_nxt    = '0;
      w_wptr_nxt     = '0;
      w_rptr_nxt     = '0;
    end else begin
      if (w_grant) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
      if (instr_rvalid_i && (r_discard != '0))
        w_discard_nxt = r_discard - CW'(1);
      if (w_push) begin
        w_resp_pc_nxt = r_resp_pc + 32'd4;
        w_wptr_nxt    = f_inc(r_wptr);
      end
      if (w_pop) w_rptr_nxt = f_inc(r_rptr);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc    <= BOOT_ADDR;
      r_resp_pc     <= BOOT_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      r_count       <= w_count_nxt;
      r_wptr        <= w_wptr_nxt;
      r_rptr        <= w_rptr_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= BOOT_ADDR;
      end
    end else if (w_push) begin
      r_mem_instr[r_wptr] <= instr_rdata_i;
      r_mem_pc[r_wptr]    <= r_resp_pc;
    end
  end

  a_rvalid_expected: assert property (
    @(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> (r_outstanding != '0));

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (w_push && !w_pop) |-> (r_count < CW'(FIFO_DEPTH)));

endmodule
